multdiv_unit: RTL

- Parametrised iterative multiply/divide unit for the pipelined core.
- Replaces the fixed 32-bit, divide-only, single-radix stall unit.
- Execute issues an operation with a start handshake. The unit stalls nothing itself; it reports `busy`.
- It returns its result through a request/grant writeback handshake to the regfile write-port arbiter, carrying a destination register and an error flag. Writeback uses the error flag to redirect the write to $rstatus.

---
 rtl/multdiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// BITS_PER_CYCLE bits per iteration, result returned through a valid/ready writeback port.
module multdiv_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned REG_BITS       = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start_valid,
    output logic                o_start_ready,
    input  logic                i_op,
    input  logic                i_signed_mode,
    input  logic [WIDTH-1:0]    i_operand_a,
    input  logic [WIDTH-1:0]    i_operand_b,
    input  logic [REG_BITS-1:0] i_dest_reg,
    input  logic                i_kill,
    output logic                o_busy,
    output logic                o_wb_valid,
    input  logic                i_wb_ready,
    output logic [REG_BITS-1:0] o_wb_reg,
    output logic [WIDTH-1:0]    o_wb_data,
    output logic                o_wb_error
);

    localparam int unsigned ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_start_ready, r_busy, r_wb_valid, r_wb_error;
    logic [REG_BITS-1:0] r_wb_reg;
    logic [WIDTH-1:0]    r_wb_data;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_op, r_signed, r_neg;
    logic [ACC_W-1:0]    r_acc, r_mc;
    logic [WIDTH-1:0]    r_q;

    logic                w_accept, w_div0, w_last, w_a_neg, w_b_neg, w_res_err;
    logic [WIDTH-1:0]    w_a_mag, w_b_mag, w_q, w_quot, w_res_data;
    logic [ACC_W-1:0]    w_acc, w_mc, w_full;

    assign w_div0  = i_op && (i_operand_b == '0);
    assign w_last  = (r_cnt == CNT_W'(ITERS - 1));
    assign w_a_neg = i_signed_mode & i_operand_a[WIDTH-1];
    assign w_b_neg = i_signed_mode & i_operand_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~i_operand_a + WIDTH'(1)) : i_operand_a;
    assign w_b_mag = w_b_neg ? (~i_operand_b + WIDTH'(1)) : i_operand_b;

    // Next-state logic; kill beats both a new start and a pending writeback
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start_valid && !i_kill) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_div0 ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_kill)      w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_kill || (r_wb_valid && i_wb_ready)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One iteration: BITS_PER_CYCLE shift-add or restoring-subtract steps
    always_comb begin
        w_acc = r_acc;
        w_mc  = r_mc;
        w_q   = r_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (!r_op) begin
                if (w_q[0]) w_acc = w_acc + w_mc;
                w_mc = w_mc << 1;
                w_q  = w_q >> 1;
            end else begin
                w_acc = {w_acc[ACC_W-2:0], w_q[WIDTH-1]};
                w_q   = w_q << 1;
                if (w_acc >= w_mc) begin
                    w_acc  = w_acc - w_mc;
                    w_q[0] = 1'b1;
                end
            end
        end
    end

    // Final sign fix-up and overflow detection on the full-width result
    always_comb begin
        w_full = r_neg ? (~w_acc + ACC_W'(1)) : w_acc;
        w_quot = r_neg ? (~w_q + WIDTH'(1)) : w_q;
        if (!r_op) begin
            w_res_err  = r_signed ? (w_full[ACC_W-1:WIDTH] != {WIDTH{w_full[WIDTH-1]}})
                                  : (w_acc[ACC_W-1:WIDTH] != '0);
            w_res_data = w_full[WIDTH-1:0];
        end else begin
            w_res_err  = r_signed & ~r_neg & w_q[WIDTH-1];
            w_res_data = w_quot;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_wb_valid    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_ready <= (w_state_nxt == S_IDLE);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_wb_valid    <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt      <= '0;
            r_op       <= 1'b0;
            r_signed   <= 1'b0;
            r_neg      <= 1'b0;
            r_acc      <= '0;
            r_mc       <= '0;
            r_q        <= '0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
            r_wb_error <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_op     <= i_op;
            r_signed <= i_signed_mode;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_q      <= i_op ? w_a_mag : w_b_mag;
            r_mc     <= ACC_W'(i_op ? w_b_mag : w_a_mag);
            r_wb_reg <= i_dest_reg;
            if (w_div0) begin
                r_wb_data  <= '0;
                r_wb_error <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_acc;
            r_mc  <= w_mc;
            r_q   <= w_q;
            if (w_last && !i_kill) begin
                r_wb_data  <= w_res_err ? '0 : w_res_data;
                r_wb_error <= w_res_err;
            end
        end
    end

    assign o_start_ready = r_start_ready;
    assign o_busy        = r_busy;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_reg      = r_wb_reg;
    assign o_wb_data     = r_wb_data;
    assign o_wb_error    = r_wb_error;

endmodule
